if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the pipelined RV32I core. It owns the program counter and issues one instruction-memory request at a time with a request/grant handshake. It loads each returned word into the IF/ID register. It accepts control-transfer targets from the `pc_control` next-PC mux and discards fetches that are on the wrong path.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `next_pc` in 32: target from `pc_control`; sampled only when `redirect`=1.
- `redirect` in 1: taken branch or jump resolved in EX; flushes the stage.
- `stall` in 1: decode cannot consume the IF/ID register this cycle.
- `imem_req` out 1: request valid (combinational, `state==IDLE`).
- `imem_addr` out 32: `{pc[31:2],2'b00}`.
- `imem_gnt` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: read data valid; arrives ≥1 cycle after the grant.
- `imem_rdata` in 32: instruction word.
- `fetch_pc` out 32: current PC register.
- `if_id_valid` out 1: IF/ID register holds a live instruction.
- `if_id_pc` out 32: PC of that instruction.
- `if_id_instr` out 32: instruction word.

## Operation
- The FSM has three states.
  - IDLE: request outstanding on the bus.
  - WAIT: granted, awaiting `imem_rvalid`.
  - FULL: response held in the skid buffer because IF/ID is occupied and stalled.
- Registers:
  - `pc`.
  - `inflight_pc`.
  - `drop` flag.
  - Skid buffer (`hold_pc`, `hold_instr`).
  - IF/ID register (`if_id_valid`, `if_id_pc`, `if_id_instr`).
- Capture condition: capture is allowed when `!if_id_valid || !stall`.
- IDLE:
  - On `imem_gnt`, set `inflight_pc<=pc`, `pc<=pc+4`, and go to WAIT.
  - Otherwise stay in IDLE with the request held stable.
- WAIT, on `imem_rvalid`:
  - If `drop`=1: discard the data, clear `drop`, and go to IDLE.
  - Else if capture is allowed: load IF/ID with `inflight_pc`/`imem_rdata` and go to IDLE.
  - Else: load the skid buffer and go to FULL.
- WAIT, no `imem_rvalid`: stay in WAIT.
- FULL: when `stall`=0, move the skid buffer into IF/ID and go to IDLE.
- IF/ID consumption:
  - If `stall`=0, `if_id_valid`=1 and no new capture occurs, clear `if_id_valid` (the instruction is consumed).
  - `stall`=1 holds all IF/ID fields unchanged.
- `redirect` has priority over every other event in the same cycle:
  - `pc<={next_pc[31:2],2'b00}`. Bits [1:0] are forced to zero; alignment faults are raised elsewhere.
  - `if_id_valid<=0` and the skid buffer is discarded.
  - In IDLE with `imem_gnt`=1 the same cycle, the granted request is wrong-path: go to WAIT with `drop<=1`. The PC still takes `next_pc`, not `pc+4`.
  - In IDLE without grant: stay in IDLE; the new address is driven next cycle.
  - In WAIT: `drop<=1`. If `imem_rvalid` is also 1 that cycle, the data is discarded and the FSM goes to IDLE with `drop` left 0.
  - In FULL: go to IDLE.
- Arithmetic: `pc+4` is 32-bit modulo, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- At most one request is outstanding. `imem_rvalid` in IDLE or FULL is a protocol violation and is ignored.

## Timing
- Reset values:
  - `pc=RESET_PC`, FSM in IDLE.
  - `imem_req=1` once `rstn` deasserts.
  - `imem_addr=RESET_PC`, `fetch_pc=RESET_PC`.
  - `drop=0`, `if_id_valid=0`.
  - `if_id_pc=0`, `if_id_instr=0`, skid buffer cleared.
- Reset asserted mid-transaction abandons the transaction. A late `imem_rvalid` arriving after reset release is ignored because the FSM is in IDLE.
- Latency for grant in cycle N and `rvalid` in cycle N+1: `if_id_valid`=1 after the edge ending N+1, and the next request is driven in N+2.
- Peak throughput is one instruction per 2 cycles.
- Redirect in cycle N:
  - `fetch_pc`/`imem_addr` show the target from N+1.
  - `if_id_valid`=0 from N+1.
- Outputs other than `imem_req`/`imem_addr` are registered.

## Test plan
- Reset, zero-wait memory (grant and rvalid 1 cycle later), no stall -> `if_id_pc` sequence 0x3000, 0x3004, 0x3008, with `if_id_valid` high every second cycle.
- Stall held 4 cycles while a response arrives -> response parks in FULL. IF/ID stays frozen, then updates on the first cycle with `stall`=0. No instruction is lost or duplicated.
- Redirect to 0x3100 while in WAIT; rvalid arrives 2 cycles later with 0xDEADBEEF -> data dropped and the next request address is 0x3100.
- Redirect and `imem_gnt` in the same IDLE cycle -> that response is dropped and the following fetch is at `next_pc`.
- Redirect coinciding with `stall`=1 and FULL -> `if_id_valid`=0 and skid buffer discarded next cycle.
- `RESET_PC`=32'hFFFF_FFFC -> second fetch address is 0x0000_0000. Assert `rstn` low while in WAIT -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time,
// and fills the IF/ID register, using a one-entry skid buffer when decode stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] fetch_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic        drop;
  fetch_t      hold;
  logic        capture_ok;
  logic [31:0] redirect_pc;

  assign capture_ok  = !if_id_valid || !stall;
  assign redirect_pc = next_pc & 32'hFFFF_FFFC;

  assign imem_req  = (state == S_IDLE);
  assign imem_addr = pc & 32'hFFFF_FFFC;
  assign fetch_pc  = pc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      inflight_pc <= '0;
      drop        <= 1'b0;
      hold        <= '0;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= '0;
    end else if (redirect) begin
      // Redirect wins over everything: flush IF/ID and skid, and mark any
      // request already on the bus as wrong-path.
      pc          <= redirect_pc;
      if_id_valid <= 1'b0;
      hold        <= '0;
      case (state)
        S_IDLE: begin
          if (imem_gnt) begin
            inflight_pc <= pc;
            drop        <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            drop  <= 1'b0;
            state <= S_IDLE;
          end else begin
            drop  <= 1'b1;
          end
        end
        S_FULL:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end else begin
      // Consumption; a capture below in the same cycle overrides this.
      if (if_id_valid && !stall)
        if_id_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (imem_gnt) begin
            inflight_pc <= pc;
            pc          <= pc + 32'd4;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_IDLE;
            end else if (capture_ok) begin
              if_id_valid <= 1'b1;
              if_id_pc    <= inflight_pc;
              if_id_instr <= imem_rdata;
              state       <= S_IDLE;
            end else begin
              hold.pc    <= inflight_pc;
              hold.instr <= imem_rdata;
              state      <= S_FULL;
            end
          end
        end
        S_FULL: begin
          if (!stall) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= hold.pc;
            if_id_instr <= hold.instr;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
